// File: rtl/switch_status_display.sv
`timescale 1ns / 1ps
// switch_status_display
// Per-channel slide-switch monitor. Each switch goes through a 2-flop
// synchroniser and a debouncer. Its stable level drives one LED. One
// 7-segment digit shows the level, or a 4-bit toggle count when MODE is
// high. The digit's decimal point flashes for a while after every
// accepted change. All outputs are registered.
module switch_status_display #(
  parameter int N_CH            = 6,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FLASH_CYCLES    = 25000000
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic [N_CH-1:0]     SW,
  input  logic                MODE,
  output logic [N_CH-1:0]     LEDR,
  output logic [8*N_CH-1:0]   HEX
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int FL_W  = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FL_W-1:0]  FL_LOAD  = FL_W'(FLASH_CYCLES);

  // Active-low segment pattern (g..a) for a hex digit, DP excluded.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    seg7 = 7'h7F;
    case (v)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      4'hF: seg7 = 7'h0E;
    endcase
  endfunction

  // Full digit byte: bit 7 is the active-low decimal point.
  function automatic logic [7:0] digit_code(input logic [3:0] v, input logic dp_on);
    digit_code = {~dp_on, seg7(v)};
  endfunction

  // Synchroniser stages
  logic [N_CH-1:0] sw_meta_q, sw_sync_q;
  logic            mode_meta_q, mode_sync_q;

  // Per-channel debounce, toggle count and flash state
  logic [N_CH-1:0]             stable_q, stable_d;
  logic [N_CH-1:0]             change;
  logic [N_CH-1:0][CNT_W-1:0]  db_cnt_q, db_cnt_d;
  logic [N_CH-1:0][3:0]        tog_cnt_q, tog_cnt_d;
  logic [N_CH-1:0][FL_W-1:0]   flash_q, flash_d;

  // Output registers
  logic [N_CH-1:0]   led_q, led_d;
  logic [8*N_CH-1:0] hex_q, hex_d;

  // Two-flop synchronisers for the asynchronous switch and mode inputs.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the chain into one stage.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      mode_meta_q <= 1'b0;
      mode_sync_q <= 1'b0;
    end else begin
      sw_meta_q   <= SW;
      sw_sync_q   <= sw_meta_q;
      mode_meta_q <= MODE;
      mode_sync_q <= mode_meta_q;
    end
  end

  // Debounce: count consecutive clocks the synchronised input disagrees
  // with the stable level; accept the new level on the last count.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned, which would otherwise infer a latch.
    stable_d = stable_q;
    change   = '0;
    db_cnt_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sw_sync_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sw_sync_q[i];
          change[i]   = 1'b1;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Event bookkeeping: bump the wrapping toggle count and (re)start the
  // flash timer on a stable change; otherwise the timer runs down to zero.
  always_comb begin
    tog_cnt_d = tog_cnt_q;
    flash_d   = flash_q;
    for (int i = 0; i < N_CH; i++) begin
      if (change[i]) begin
        tog_cnt_d[i] = tog_cnt_q[i] + 4'd1;
        flash_d[i]   = FL_LOAD;
      end else if (flash_q[i] != '0) begin
        flash_d[i] = flash_q[i] - 1'b1;
      end
    end
  end

  // Next output values from the registered channel state and mode.
  always_comb begin
    led_d = stable_q;
    hex_d = '1;
    for (int i = 0; i < N_CH; i++) begin
      hex_d[8*i +: 8] = digit_code(mode_sync_q ? tog_cnt_q[i] : {3'b000, stable_q[i]},
                                   flash_q[i] != '0);
    end
  end

  // Channel state registers.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      stable_q  <= '0;
      db_cnt_q  <= '0;
      tog_cnt_q <= '0;
      flash_q   <= '0;
    end else begin
      stable_q  <= stable_d;
      db_cnt_q  <= db_cnt_d;
      tog_cnt_q <= tog_cnt_d;
      flash_q   <= flash_d;
    end
  end

  // Output registers; digits reset to blank rather than to a drawn '0'.
  // NOTE: every register in this block has an explicit reset value, so the
  // board never shows stale or random segments coming out of reset.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      led_q <= '0;
      hex_q <= '1;
    end else begin
      led_q <= led_d;
      hex_q <= hex_d;
    end
  end

  assign LEDR = led_q;
  assign HEX  = hex_q;

endmodule

// File: doc/switch_status_display.md
Name: switch_status_display

Overview:
- Parametrised N-channel switch monitor driving one LED and one 7-segment digit per slide switch.
- Each switch is synchronised and debounced, and its stable level is shown on its LED.
- Its digit shows either the level (0/1) or a 4-bit toggle count (0-F), selected by MODE.
- The decimal point flashes after every stable change.
- Sits directly under the board top level, between SW/LEDR/HEX pins and the rest of the design.

Parameters:
- N_CH, 6, number of channels (1..6); channel i uses SW[i], LEDR[i], HEX[8i+7:8i].
- DEBOUNCE_CYCLES, 500000, consecutive clocks the synchronised input must differ from the stable level before it is accepted (10 ms at 50 MHz); minimum 2.
- FLASH_CYCLES, 25000000, clocks the decimal point stays lit after a stable change (0.5 s at 50 MHz); minimum 1.

Ports:
- CLOCK_50  input  1  system clock; all state on rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- SW  input  N_CH  raw slide switches, asynchronous to CLOCK_50; 1 = up.
- MODE  input  1  0 = show level, 1 = show toggle count; asynchronous, synchronised internally.
- LEDR  output  N_CH  debounced stable level per channel; 1 = lit.
- HEX  output  8*N_CH  active-low segments per digit; bit 7 = DP, bits 6..0 = g..a.

Behaviour:
- Reset, while RESET_N=0:
  - all synchronisers, stable levels, debounce counters, toggle counts and flash timers go to 0;
  - LEDR = 0; every HEX digit = 8'hFF (blank).
- First clock after release: each digit shows '0' with DP off (8'hC0).
- All outputs are registered; no combinational path from SW or MODE to outputs.
- Synchroniser: 2-flop chain per SW bit and for MODE.
- Debounce, per channel (counter width = clog2(DEBOUNCE_CYCLES)):
  - if sync == stable, counter clears to 0;
  - else counter increments;
  - when counter == DEBOUNCE_CYCLES-1 while sync != stable, stable <= sync and counter clears.
- Debounce boundaries:
  - a glitch shorter than DEBOUNCE_CYCLES clocks never changes stable;
  - any return to the stable level restarts the count.
- Latency: a clean SW edge reaches LEDR exactly 2 + DEBOUNCE_CYCLES + 1 clocks later; HEX changes on the same clock as LEDR.
- Stable change event, the clock stable toggles:
  - that channel's toggle count increments mod 16 (F wraps to 0);
  - its flash timer loads FLASH_CYCLES.
- Flash timer:
  - decrements to 0 and holds there;
  - DP is lit (bit7 = 0) while the timer is non-zero;
  - a new event during a flash reloads the timer (flash extended, not queued).
- Digit value:
  - MODE_sync = 0: stable level (0 or 1);
  - MODE_sync = 1: toggle count.
- MODE changes take effect on all digits on the same clock; counts are not cleared by MODE.
- Segment codes (DP off), 0..F:
  - 0..7: C0, F9, A4, B0, 99, 92, 82, F8;
  - 8..F: 80, 90, 88, 83, C6, A1, 86, 8E.
- DP on clears bit 7 of the code, e.g. '1' with DP = 8'h79.
- Channels are fully independent; simultaneous changes on several channels are each processed on the same clock.
- Reset asserted mid-debounce or mid-flash:
  - all state clears immediately;
  - no event is generated on release, even if SW is up (stable starts at 0 and debounces up normally).

Test Plan (DEBOUNCE_CYCLES=4, FLASH_CYCLES=8, N_CH=6):
- Reset then release with SW=0 -> during reset LEDR=0, HEX all 8'hFF; one clock after release every digit = 8'hC0.
- SW[2] 0->1 held -> LEDR[2]=1 and HEX[23:16]=8'h79 exactly 7 clocks after the SW edge; DP clears after 8 more clocks, leaving 8'hF9.
- SW[0] pulses high for 3 clocks (sync side) -> LEDR[0] stays 0, HEX[7:0] stays 8'hC0, no DP.
- MODE=1, toggle SW[5] 17 times with full debounce each -> count wraps; HEX[47:40] = 8'hF9 (count 1) with DP off once idle.
- Second SW[1] change 3 clocks after the first event -> DP held low continuously and extinguishes 8 clocks after the second event.
- Assert RESET_N low 2 clocks into a debounce, release with SW[3]=1 held -> all outputs blank during reset; LEDR[3] rises 7 clocks after release, toggle count = 1.
